led_matrix_frame_decoder: RTL and testbench

- Receive-side counterpart of the snake LED matrix driver. It observes the 8x8 matrix drive bus: tierras are active-low row grounds, voltajes are active-high column drives.
- Accumulates the time-multiplexed drive over a fixed frame window and presents a registered 64-pixel snapshot with a lit-pixel count, head (first lit pixel) coordinate, change flag and drive-error flag.
- Feeds game logic (collision/score) and serves as a self-check monitor on the matrix bus.

---
 rtl/led_matrix_frame_decoder.sv | 150 +++++++++++++++
 tb/tb_led_matrix_frame_decoder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_frame_decoder.sv
// rtl/led_matrix_frame_decoder.sv - 8x8 LED matrix drive-bus frame decoder
//
// Observes the time-multiplexed matrix drive bus and accumulates it over a
// fixed window of enabled cycles. At the close of each window it loads a
// registered 64-pixel snapshot together with summary information.
//
// Ports:
//   clk           rising-edge system clock
//   reset         synchronous, active-high reset
//   en            sample enable; counter and accumulator hold when low
//   tierras[7:0]  row grounds, active-low (bit i low selects row i)
//   voltajes[7:0] column drives, active-high (bit 7 = column 0)
//   rd_row[2:0]   snapshot read address
//   rd_data[7:0]  snapshot row rd_row (combinational read)
//   frame[63:0]   snapshot, row r in bits [8r+7:8r]
//   frame_valid   one-cycle pulse when a new snapshot is loaded
//   pixel_count   lit pixels in the snapshot (0..64)
//   head_found    snapshot has at least one lit pixel
//   head_row/col  coordinate of the first lit pixel (row-major, column 0 first)
//   frame_changed snapshot differs from the previous one
//   multi_row_err more than one row was selected in some sample of the window

module led_matrix_frame_decoder #(
    parameter int FRAME_CYCLES = 8,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [7:0]  tierras,
    input  logic [7:0]  voltajes,
    input  logic [2:0]  rd_row,
    output logic [7:0]  rd_data,
    output logic [63:0] frame,
    output logic        frame_valid,
    output logic [6:0]  pixel_count,
    output logic        head_found,
    output logic [2:0]  head_row,
    output logic [2:0]  head_col,
    output logic        frame_changed,
    output logic        multi_row_err
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(FRAME_CYCLES - 1);

    logic [63:0]      r_accum;
    logic             r_err_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [63:0]      r_frame;
    logic             r_frame_valid;
    logic [6:0]       r_pixel_count;
    logic             r_head_found;
    logic [2:0]       r_head_row;
    logic [2:0]       r_head_col;
    logic             r_frame_changed;
    logic             r_multi_row_err;

    logic [7:0]       w_sel;
    logic [63:0]      w_contrib;
    logic [63:0]      w_next;
    logic             w_multi;
    logic             w_close;
    logic [6:0]       w_pop;
    logic             w_head_found;
    logic [2:0]       w_head_row;
    logic [2:0]       w_head_col;

    // This cycle's contribution and the candidate snapshot including it.
    always_comb begin
        w_sel     = ~tierras;
        w_contrib = '0;
        for (int i = 0; i < 8; i++) begin
            w_contrib[8*i +: 8] = w_sel[i] ? voltajes : 8'h00;
        end
        w_next  = r_accum | w_contrib;
        // Clearing the lowest set bit leaves something only if two or more rows are selected.
        w_multi = (w_sel & (w_sel - 8'd1)) != 8'd0;
        w_close = en && (r_cnt == C_LAST);
    end

    always_comb begin
        w_pop = '0;
        for (int k = 0; k < 64; k++) begin
            w_pop = w_pop + {6'd0, w_next[k]};
        end
    end

    // Scan in reverse priority so the last hit written is the first pixel in
    // row-major order; column c lives at bit 7-c of its row.
    always_comb begin
        w_head_found = 1'b0;
        w_head_row   = '0;
        w_head_col   = '0;
        for (int r = 7; r >= 0; r--) begin
            for (int c = 7; c >= 0; c--) begin
                if (w_next[8*r + 7 - c]) begin
                    w_head_found = 1'b1;
                    w_head_row   = 3'(r);
                    w_head_col   = 3'(c);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_accum         <= '0;
            r_err_acc       <= 1'b0;
            r_cnt           <= '0;
            r_frame         <= '0;
            r_frame_valid   <= 1'b0;
            r_pixel_count   <= '0;
            r_head_found    <= 1'b0;
            r_head_row      <= '0;
            r_head_col      <= '0;
            r_frame_changed <= 1'b0;
            r_multi_row_err <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            if (w_close) begin
                r_frame         <= w_next;
                r_pixel_count   <= w_pop;
                r_head_found    <= w_head_found;
                r_head_row      <= w_head_row;
                r_head_col      <= w_head_col;
                r_frame_changed <= (w_next != r_frame);
                r_multi_row_err <= r_err_acc | w_multi;
                r_frame_valid   <= 1'b1;
                r_accum         <= '0;
                r_err_acc       <= 1'b0;
                r_cnt           <= '0;
            end else if (en) begin
                r_accum   <= w_next;
                r_err_acc <= r_err_acc | w_multi;
                r_cnt     <= r_cnt + 1'b1;
            end
        end
    end

    assign rd_data       = r_frame[{rd_row, 3'b000} +: 8];
    assign frame         = r_frame;
    assign frame_valid   = r_frame_valid;
    assign pixel_count   = r_pixel_count;
    assign head_found    = r_head_found;
    assign head_row      = r_head_row;
    assign head_col      = r_head_col;
    assign frame_changed = r_frame_changed;
    assign multi_row_err = r_multi_row_err;

endmodule

// File: tb/tb_led_matrix_frame_decoder.sv
// tb/tb_led_matrix_frame_decoder.sv - self-checking bench for led_matrix_frame_decoder

module tb_led_matrix_frame_decoder;

    localparam int FC = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [7:0]  tierras = 8'hFF;
    logic [7:0]  voltajes = 8'h00;
    logic [2:0]  rd_row = 3'd0;
    logic [7:0]  rd_data;
    logic [63:0] frame;
    logic        frame_valid;
    logic [6:0]  pixel_count;
    logic        head_found;
    logic [2:0]  head_row;
    logic [2:0]  head_col;
    logic        frame_changed;
    logic        multi_row_err;

    led_matrix_frame_decoder #(.FRAME_CYCLES(FC), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .en(en), .tierras(tierras), .voltajes(voltajes),
        .rd_row(rd_row), .rd_data(rd_data), .frame(frame), .frame_valid(frame_valid),
        .pixel_count(pixel_count), .head_found(head_found), .head_row(head_row),
        .head_col(head_col), .frame_changed(frame_changed), .multi_row_err(multi_row_err)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: per-row bytes OR'd over a window of FC enabled cycles.
    logic [7:0] m_acc [8];
    logic       m_err;
    int         m_cnt;
    logic [7:0] e_frame [8];
    logic       e_valid, e_hf, e_changed, e_err;
    int         e_count, e_hr, e_hc;
    bit         m_started = 0;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin m_acc[i] = 0; e_frame[i] = 0; end
            m_err = 0; m_cnt = 0; e_valid = 0; e_hf = 0; e_changed = 0; e_err = 0;
            e_count = 0; e_hr = 0; e_hc = 0;
            m_started = 1;
        end else if (m_started) begin
            e_valid = 0;
            if (en) begin
                for (int i = 0; i < 8; i++) if (!tierras[i]) m_acc[i] = m_acc[i] | voltajes;
                if ($countones(~tierras) >= 2) m_err = 1;
                m_cnt++;
                if (m_cnt == FC) begin
                    e_count = 0; e_hf = 0; e_hr = 0; e_hc = 0; e_changed = 0;
                    for (int r = 0; r < 8; r++) begin
                        e_count += $countones(m_acc[r]);
                        if (m_acc[r] != e_frame[r]) e_changed = 1;
                        for (int c = 0; c < 8; c++)
                            if (m_acc[r][7-c] && !e_hf) begin e_hf = 1; e_hr = r; e_hc = c; end
                    end
                    for (int r = 0; r < 8; r++) begin e_frame[r] = m_acc[r]; m_acc[r] = 0; end
                    e_err = m_err; m_err = 0; m_cnt = 0; e_valid = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            logic [63:0] ef;
            for (int r = 0; r < 8; r++) ef[8*r +: 8] = e_frame[r];
            chk("frame", frame, ef);
            chk("rd_data", {56'd0, rd_data}, {56'd0, e_frame[rd_row]});
            chk("frame_valid", {63'd0, frame_valid}, {63'd0, e_valid});
            chk("pixel_count", {57'd0, pixel_count}, 64'(e_count));
            chk("head_found", {63'd0, head_found}, {63'd0, e_hf});
            chk("head_row", {61'd0, head_row}, 64'(e_hr));
            chk("head_col", {61'd0, head_col}, 64'(e_hc));
            chk("frame_changed", {63'd0, frame_changed}, {63'd0, e_changed});
            chk("multi_row_err", {63'd0, multi_row_err}, {63'd0, e_err});
        end
    end

    task automatic step(input logic r, input logic e, input logic [7:0] t, input logic [7:0] v);
        @(posedge clk);
        #1;
        reset = r; en = e; tierras = t; voltajes = v; rd_row = 3'($urandom);
    endtask

    task automatic window(input logic [7:0] t, input logic [7:0] v);
        for (int i = 0; i < FC; i++) step(0, 1, t, v);
        step(0, 0, 8'hFF, 8'h00);
    endtask

    task automatic rdchk(input string name, input logic [2:0] row, input logic [7:0] exp);
        rd_row = row;
        #1;
        chk(name, {56'd0, rd_data}, {56'd0, exp});
    endtask

    initial begin
        logic [7:0] t, v;
        step(1, 0, 8'hFF, 8'h00);
        // single-row capture
        step(0, 1, 8'hDF, 8'hC0);
        chk("reset_frame", frame, 64'd0);
        chk("reset_valid", {63'd0, frame_valid}, 64'd0);
        chk("reset_count", {57'd0, pixel_count}, 64'd0);
        for (int i = 1; i < FC; i++) step(0, 1, 8'hDF, 8'hC0);
        step(0, 0, 8'hFF, 8'h00);
        chk("t1_valid", {63'd0, frame_valid}, 64'd1);
        chk("t1_count", {57'd0, pixel_count}, 64'd2);
        chk("t1_head", {56'd0, head_found, head_row, 1'b0, head_col}, {56'd0, 1'b1, 3'd5, 1'b0, 3'd0});
        chk("t1_flags", {62'd0, frame_changed, multi_row_err}, 64'd2);
        rdchk("t1_rd5", 3'd5, 8'hC0);
        // accumulation
        step(0, 1, 8'hDF, 8'hC0); step(0, 1, 8'hDF, 8'h60);
        step(0, 1, 8'hDF, 8'h30); step(0, 1, 8'hDF, 8'h18);
        step(0, 0, 8'hFF, 8'h00);
        rdchk("t2_rd5", 3'd5, 8'hF8);
        chk("t2_count", {57'd0, pixel_count}, 64'd5);
        chk("t2_headcol", {61'd0, head_col}, 64'd0);
        step(0, 1, 8'hDF, 8'hC0); step(0, 1, 8'hDF, 8'h60);
        step(0, 1, 8'hDF, 8'h30); step(0, 1, 8'hDF, 8'h18);
        step(0, 0, 8'hFF, 8'h00);
        chk("t2_unchanged", {63'd0, frame_changed}, 64'd0);
        // blank and multi-select
        window(8'hFF, 8'hAA);
        chk("t3_blank_frame", frame, 64'd0);
        chk("t3_blank_hf", {57'd0, head_found, pixel_count}, 64'd0);
        chk("t3_blank_changed", {63'd0, frame_changed}, 64'd1);
        window(8'hDB, 8'h81);
        chk("t3_multi_frame", frame, 64'h0000_8100_0081_0000);
        chk("t3_multi_count", {57'd0, pixel_count}, 64'd4);
        chk("t3_multi_head", {58'd0, head_row, head_col}, {58'd0, 3'd2, 3'd0});
        chk("t3_multi_err", {63'd0, multi_row_err}, 64'd1);
        window(8'hDF, 8'h01);
        chk("t3_clean_err", {63'd0, multi_row_err}, 64'd0);
        // enable gating
        step(0, 1, 8'hEF, 8'h10); step(0, 1, 8'hEF, 8'h10);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 8'hFE, 8'hFF);
            chk("t4_no_valid", {63'd0, frame_valid}, 64'd0);
        end
        step(0, 1, 8'hEF, 8'h10); step(0, 1, 8'hEF, 8'h10);
        step(0, 0, 8'hFF, 8'h00);
        chk("t4_valid", {63'd0, frame_valid}, 64'd1);
        chk("t4_frame", frame, 64'h0000_0010_0000_0000);
        rdchk("t4_rd0", 3'd0, 8'h00);
        // reset mid-window
        for (int i = 0; i < FC - 1; i++) step(0, 1, 8'hFD, 8'hFF);
        step(1, 1, 8'hFD, 8'hFF);
        step(0, 1, 8'hF7, 8'h01);
        chk("t5_rst_frame", frame, 64'd0);
        chk("t5_rst_valid", {63'd0, frame_valid}, 64'd0);
        for (int i = 1; i < FC; i++) begin
            step(0, 1, 8'hF7, 8'h01);
            chk("t5_no_valid", {63'd0, frame_valid}, 64'd0);
        end
        step(0, 0, 8'hFF, 8'h00);
        chk("t5_valid", {63'd0, frame_valid}, 64'd1);
        chk("t5_frame", frame, 64'h0000_0000_0100_0000);
        // back-to-back windows
        for (int k = 0; k <= 3 * FC; k++) begin
            if (k < 3 * FC) step(0, 1, 8'($urandom), 8'($urandom));
            else step(0, 0, 8'hFF, 8'h00);
            chk("t6_pulse", {63'd0, frame_valid}, {63'd0, (k > 0 && k % FC == 0)});
        end
        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel == 0) t = 8'hFF;
            else if (sel == 1) t = 8'($urandom);
            else t = ~(8'h01 << $urandom_range(0, 7));
            v = 8'($urandom);
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) != 0), t, v);
        end
        step(0, 0, 8'hFF, 8'h00);
        step(0, 0, 8'hFF, 8'h00);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
